// File: rtl/fadd_pkg.sv
// fadd_pkg: definitions shared by the FloatAdd adder path.
//   - KGP_* : 2-bit kill/generate/propagate carry codes used between
//             4-bit slices (00 = kill, 11 = generate, 01/10 = propagate).
//   - state_e : sequencer state encoding (IDLE / RUN / DONE).
//   - kgp_resolve : turns a slice carry-out code plus the carry that entered
//                   the slice into the actual carry bit.
package fadd_pkg;

    localparam logic [1:0] KGP_KILL  = 2'b00;
    localparam logic [1:0] KGP_GEN   = 2'b11;
    localparam logic [1:0] KGP_PROP0 = 2'b01;
    localparam logic [1:0] KGP_PROP1 = 2'b10;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    function automatic logic kgp_resolve(input logic [1:0] code, input logic cin);
        logic c;
        case (code)
            KGP_KILL:  c = 1'b0;
            KGP_GEN:   c = 1'b1;
            KGP_PROP0: c = cin;
            KGP_PROP1: c = cin;
            default:   c = cin;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/nibble_serial_add_ctrl.sv
// nibble_serial_add_ctrl: time-shares one external 4-bit adder slice to add
// or subtract two WIDTH-bit operands, one nibble per clock, LSB first. The
// carry between nibbles is threaded through the slice as a kill/generate code.
// One operation is in flight at a time.
//
// Ports:
//   clk, rst         rising-edge clock, synchronous active-high reset
//   in_valid/ready   request handshake; in_a, in_b, in_cin, in_sub sampled
//                    only on acceptance (in_cin ignored when in_sub=1)
//   out_valid/ready  result handshake; out_sum, out_cout, out_ovf held
//                    stable while out_valid=1 and out_ready=0
//   slice_a/b/kin    nibble operands and carry-in code to the slice
//   slice_sum/kout   combinational slice result and carry-out code
//
// WIDTH must be a multiple of 4 and at least 8. A request accepted on edge T
// produces out_valid after edge T+NIB.
module nibble_serial_add_ctrl
    import fadd_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_cin,
    input  logic             in_sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_cout,
    output logic             out_ovf,
    output logic [3:0]       slice_a,
    output logic [3:0]       slice_b,
    output logic [1:0]       slice_kin,
    input  logic [3:0]       slice_sum,
    input  logic [1:0]       slice_kout
);

    localparam int NIB   = WIDTH / 4;
    localparam int IDX_W = (NIB > 1) ? $clog2(NIB) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NIB - 1);

    state_e           state_q;
    logic [IDX_W-1:0] idx_q;
    logic             carry_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;     // already inverted for subtraction
    logic [WIDTH-1:0] res_q;
    logic             carry_d;

    assign carry_d = kgp_resolve(slice_kout, carry_q);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            carry_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        a_q     <= in_a;
                        // Subtraction is A + ~B + 1: invert B and force carry-in.
                        b_q     <= in_sub ? ~in_b : in_b;
                        carry_q <= in_sub ? 1'b1 : in_cin;
                        idx_q   <= '0;
                        state_q <= RUN;
                    end
                end
                RUN: begin
                    res_q[4*idx_q +: 4] <= slice_sum;
                    carry_q             <= carry_d;
                    if (idx_q == IDX_LAST) begin
                        // idx stays parked at the last nibble; it is reloaded on acceptance.
                        state_q <= DONE;
                    end else begin
                        idx_q <= idx_q + IDX_W'(1);
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // in_ready is held low during reset even though state already reads IDLE.
    assign in_ready  = (state_q == IDLE) && !rst;
    assign out_valid = (state_q == DONE);

    // Result outputs are forced to zero outside DONE so no partial sum is visible.
    assign out_sum  = out_valid ? res_q : '0;
    assign out_cout = out_valid && carry_q;
    assign out_ovf  = out_valid && (a_q[WIDTH-1] == b_q[WIDTH-1])
                                && (res_q[WIDTH-1] != a_q[WIDTH-1]);

    always_comb begin
        slice_a   = 4'h0;
        slice_b   = 4'h0;
        slice_kin = KGP_KILL;
        if (state_q == RUN) begin
            slice_a   = a_q[4*idx_q +: 4];
            slice_b   = b_q[4*idx_q +: 4];
            slice_kin = carry_q ? KGP_GEN : KGP_KILL;
        end
    end

endmodule
